// File: rtl/fft_peak_reader.sv
// fft_peak_reader
//   Sweeps the positive-frequency half of an FFT result memory (bins 1..N/2-1),
//   computes re^2+im^2 for each bin and reports the bin with the largest
//   magnitude. The lowest bin wins ties.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   fft_done   : starts a sweep when sampled high in IDLE
//   rd_adr     : read address into the result memory (0 while idle)
//   rd_data    : {signed real, signed imag}, valid one cycle after rd_adr
//   busy       : high while a sweep is in progress
//   peak_valid : one-cycle pulse when peak_bin/peak_mag carry a new result
//   peak_bin   : bin index of the maximum magnitude
//   peak_mag   : unsigned re^2+im^2 of peak_bin
module fft_peak_reader #(
  parameter int bit_width = 16,
  parameter int N         = 512,
  parameter int M         = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  output logic [M-1:0]           rd_adr,
  input  logic [2*bit_width-1:0] rd_data,
  output logic                   busy,
  output logic                   peak_valid,
  output logic [M-1:0]           peak_bin,
  output logic [2*bit_width-1:0] peak_mag
);

  localparam logic [M-1:0] FIRST_ADR = M'(1);
  localparam logic [M-1:0] LAST_ADR  = M'(N/2 - 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, REPORT} state_t;

  state_t state, state_nxt;
  logic   flush_cnt;

  // Squared magnitude. Each square is at most 2^(2*bit_width-2), so the
  // signed products never wrap; the sum needs the full unsigned range.
  function automatic logic [2*bit_width-1:0] mag_sq(
    input logic signed [bit_width-1:0] re,
    input logic signed [bit_width-1:0] im
  );
    logic signed [2*bit_width-1:0] re_x, im_x, re_sq, im_sq;
    re_x  = {{bit_width{re[bit_width-1]}}, re};
    im_x  = {{bit_width{im[bit_width-1]}}, im};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    return $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fft_done) state_nxt = READ;
      READ:    if (rd_adr == LAST_ADR) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    peak_valid = (state == REPORT);
  end

  // Address counter: loads 1 on entry to READ, increments while staying in
  // READ, and parks at 0 otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_adr    <= '0;
      flush_cnt <= 1'b0;
    end else begin
      if (state_nxt == READ)
        rd_adr <= (state == READ) ? rd_adr + M'(1) : FIRST_ADR;
      else
        rd_adr <= '0;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
    end
  end

  // p1: memory output for the address presented last cycle
  logic [M-1:0]                 bin_p1;
  logic                         vld_p1;
  logic signed [bit_width-1:0]  re_p1, im_p1;

  assign re_p1 = $signed(rd_data[2*bit_width-1:bit_width]);
  assign im_p1 = $signed(rd_data[bit_width-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      bin_p1 <= rd_adr;
      vld_p1 <= (state == READ);
    end
  end

  // p2: registered magnitude with its bin tag
  logic [2*bit_width-1:0] mag_p2;
  logic [M-1:0]           bin_p2;
  logic                   vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      mag_p2 <= '0;
      bin_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      mag_p2 <= mag_sq(re_p1, im_p1);
      bin_p2 <= bin_p1;
      vld_p2 <= vld_p1;
    end
  end

  // Compare: running max. The candidate is used combinationally so the last
  // bin's compare lands in the peak registers on the edge into REPORT.
  logic [2*bit_width-1:0] max_mag, cand_mag;
  logic [M-1:0]           max_bin, cand_bin;
  logic                   take;

  always_comb begin
    take     = vld_p2 && ((bin_p2 == FIRST_ADR) || (mag_p2 > max_mag));
    cand_mag = take ? mag_p2 : max_mag;
    cand_bin = take ? bin_p2 : max_bin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_mag  <= '0;
      max_bin  <= '0;
      peak_mag <= '0;
      peak_bin <= '0;
    end else begin
      max_mag <= cand_mag;
      max_bin <= cand_bin;
      if (state == FLUSH && flush_cnt) begin
        peak_mag <= cand_mag;
        peak_bin <= cand_bin;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_reader.sv
module tb_fft_peak_reader;

  localparam int BW = 16;
  localparam int NN = 512;
  localparam int MM = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fft_done = 1'b0;
  logic [MM-1:0]     rd_adr;
  logic [2*BW-1:0]   rd_data = '0;
  logic              busy, peak_valid;
  logic [MM-1:0]     peak_bin;
  logic [2*BW-1:0]   peak_mag;

  logic [2*BW-1:0]   mem [NN];

  int n_checks = 0;
  int n_errors = 0;

  fft_peak_reader #(.bit_width(BW), .N(NN), .M(MM)) dut (
    .clk(clk), .reset(reset), .fft_done(fft_done), .rd_adr(rd_adr),
    .rd_data(rd_data), .busy(busy), .peak_valid(peak_valid),
    .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  // Result memory with one cycle of read latency
  always @(posedge clk) rd_data <= mem[rd_adr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*BW-1:0] pack(input int re, input int im);
    logic [BW-1:0] r, i;
    r = re[BW-1:0];
    i = im[BW-1:0];
    return {r, i};
  endfunction

  task automatic fill(input int re, input int im);
    for (int k = 0; k < NN; k++) mem[k] = pack(re, im);
  endtask

  // One sweep: fft_done pulsed so it is sampled at the end of cycle 0.
  // redo_at / rst_at (>0) drive fft_done / reset during that cycle number.
  task automatic sweep(input string name, input int redo_at, input int rst_at,
                       input bit exp_pulse, input int exp_bin, input longint exp_mag);
    int vcyc, npulse, zero_adr, busy_bad;
    logic [MM-1:0]   got_bin;
    logic [2*BW-1:0] got_mag;
    bit exp_busy;
    vcyc = -1; npulse = 0; zero_adr = 0; busy_bad = 0;
    got_bin = '0; got_mag = '0;
    @(negedge clk); fft_done = 1'b1;
    @(negedge clk); fft_done = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1)   chk({name, "_adr_first"}, rd_adr, 1);
      if (c == 255 && rst_at == 0) chk({name, "_adr_last"}, rd_adr, 255);
      if (c <= 255 && (rst_at == 0 || c <= rst_at) && rd_adr == 0) zero_adr++;
      exp_busy = (rst_at > 0) ? (c <= rst_at) : (c <= 258);
      if (busy !== exp_busy) busy_bad++;
      if (peak_valid) begin
        npulse++;
        if (vcyc < 0) begin
          vcyc = c; got_bin = peak_bin; got_mag = peak_mag;
        end
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        chk({name, "_rst_adr"},  rd_adr, 0);
        chk({name, "_rst_busy"}, busy, 0);
        chk({name, "_rst_pv"},   peak_valid, 0);
        chk({name, "_rst_bin"},  peak_bin, 0);
        chk({name, "_rst_mag"},  peak_mag, 0);
      end
      fft_done = (c == redo_at);
      reset    = (c == rst_at);
    end
    fft_done = 1'b0; reset = 1'b0;
    chk({name, "_busy_profile"}, busy_bad, 0);
    chk({name, "_bin0_reads"}, zero_adr, 0);
    if (exp_pulse) begin
      chk({name, "_pulses"}, npulse, 1);
      chk({name, "_valid_cycle"}, vcyc, 258);
      chk({name, "_bin"}, got_bin, exp_bin);
      chk({name, "_mag"}, got_mag, exp_mag);
      chk({name, "_bin_hold"}, peak_bin, exp_bin);
    end else begin
      chk({name, "_pulses"}, npulse, 0);
    end
  endtask

  initial begin
    fill(0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_adr",  rd_adr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pv",   peak_valid, 0);
    chk("reset_bin",  peak_bin, 0);
    chk("reset_mag",  peak_mag, 0);

    // fft_done ignored while idle only when low; idle output stays at 0
    repeat (2) @(negedge clk);
    chk("idle_adr", rd_adr, 0);

    // Single tone
    fill(1, 1);
    mem[37] = pack(1000, 0);
    sweep("tone", 0, 0, 1'b1, 37, 64'd1000000);

    // Tie: lowest bin wins
    fill(0, 0);
    mem[20] = pack(0, -300);
    mem[90] = pack(0, -300);
    sweep("tie", 0, 0, 1'b1, 20, 64'd90000);

    // All-zero spectrum
    fill(0, 0);
    sweep("zero", 0, 0, 1'b1, 1, 64'd0);

    // Extremes; bin 0 carries a large value that must never be read
    fill(0, 0);
    mem[255] = pack(-32768, -32768);
    mem[0]   = pack(32767, 32767);
    sweep("ext", 0, 0, 1'b1, 255, 64'd2147483648);

    // fft_done during busy is ignored
    fill(1, 1);
    mem[37] = pack(1000, 0);
    sweep("redo", 100, 0, 1'b1, 37, 64'd1000000);

    // Reset mid-sweep aborts without a pulse
    fill(0, 0);
    mem[200] = pack(5, 5);
    sweep("abort", 0, 50, 1'b0, 0, 64'd0);

    // fft_done held high: next sweep starts right after REPORT
    begin
      int pv_cyc;
      int guard;
      pv_cyc = -1;
      @(negedge clk); fft_done = 1'b1;
      for (int c = 1; c <= 262; c++) begin
        @(negedge clk);
        if (peak_valid && pv_cyc < 0) pv_cyc = c;
        if (c == 259) chk("hold_idle_gap", busy, 0);
        if (c == 260) chk("hold_restart_busy", busy, 1);
        if (c == 260) chk("hold_restart_adr", rd_adr, 1);
      end
      chk("hold_valid_cycle", pv_cyc, 258);
      fft_done = 1'b0;
      guard = 0;
      while (busy && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      chk("hold_drain_timeout", guard < 400, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
